// File: rtl/md5_pad.sv
// md5_pad: MD5 message padder. Passes message words straight through to the
// MD5 core, appends the 0x80 marker and zero fill, and closes the message
// with the 64-bit little-endian bit length in words 14/15 of the final block.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   in_valid     in   input word valid
//   in_ready     out  input word accepted this cycle (combinational)
//   in_data      in   [31:0] message word, byte 0 in bits [7:0]
//   in_last      in   final word of the message
//   in_nbytes    in   [2:0] valid bytes in the final word (0..4)
//   out_valid    out  output word valid (combinational)
//   out_ready    in   downstream accepts output word
//   out_data     out  [31:0] padded block word
//   out_idx      out  [3:0] word index within current 512-bit block
//   out_blk_last out  out_idx == 15
//   out_msg_last out  final word of the message (length high word)
module md5_pad (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_idx,
    output logic        out_blk_last,
    output logic        out_msg_last
);

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned BYTE_CNT_W = 61;
    localparam int unsigned LEN_W      = 64;

    typedef enum logic [1:0] {
        S_DATA,
        S_PAD,
        S_LEN_LO,
        S_LEN_HI
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        wcnt_q, wcnt_d;
    logic [BYTE_CNT_W-1:0]   bytecnt_q, bytecnt_d;
    logic                    mpend_q, mpend_d;

    logic [2:0]              nb_eff;
    logic [WORD_W-1:0]       last_data;
    logic [LEN_W-1:0]        bitlen;

    // Out-of-range byte counts are treated as a full word so the FSM always
    // terminates the message.
    assign nb_eff = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    assign bitlen = {bytecnt_q, 3'b000};

    // Final word: keep valid bytes, drop the marker right after them, zero the rest.
    always_comb begin
        last_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nb_eff) begin
                last_data[8*i +: 8] = in_data[8*i +: 8];
            end else if (3'(i) == nb_eff) begin
                last_data[8*i +: 8] = 8'h80;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_DATA;
            wcnt_q    <= '0;
            bytecnt_q <= '0;
            mpend_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            bytecnt_q <= bytecnt_d;
            mpend_q   <= mpend_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        bytecnt_d    = bytecnt_q;
        mpend_d      = mpend_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_msg_last = 1'b0;

        unique case (state_q)
            S_DATA: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                out_data  = in_last ? last_data : in_data;
                if (in_valid && out_ready) begin
                    wcnt_d = wcnt_q + IDX_W'(1);
                    if (in_last) begin
                        bytecnt_d = bytecnt_q + BYTE_CNT_W'(nb_eff);
                        if (nb_eff == 3'd4) begin
                            // No room for the marker: it goes out as the next pad word.
                            mpend_d = 1'b1;
                            state_d = S_PAD;
                        end else if (wcnt_q == IDX_W'(13)) begin
                            state_d = S_LEN_LO;
                        end else begin
                            state_d = S_PAD;
                        end
                    end else begin
                        bytecnt_d = bytecnt_q + BYTE_CNT_W'(4);
                    end
                end
            end

            S_PAD: begin
                out_valid = 1'b1;
                out_data  = mpend_q ? WORD_W'(32'h0000_0080) : '0;
                if (out_ready) begin
                    wcnt_d  = wcnt_q + IDX_W'(1);
                    mpend_d = 1'b0;
                    // After any pad word the marker is out, so idx 13 ends the fill.
                    if (wcnt_q == IDX_W'(13)) begin
                        state_d = S_LEN_LO;
                    end
                end
            end

            S_LEN_LO: begin
                out_valid = 1'b1;
                out_data  = bitlen[31:0];
                if (out_ready) begin
                    wcnt_d  = wcnt_q + IDX_W'(1);
                    state_d = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                out_valid    = 1'b1;
                out_data     = bitlen[63:32];
                out_msg_last = 1'b1;
                if (out_ready) begin
                    wcnt_d    = '0;
                    bytecnt_d = '0;
                    mpend_d   = 1'b0;
                    state_d   = S_DATA;
                end
            end

            default: begin
                state_d = S_DATA;
            end
        endcase

        // Handshakes and payload are quiet while reset is held.
        if (reset) begin
            in_ready     = 1'b0;
            out_valid    = 1'b0;
            out_data     = '0;
            out_msg_last = 1'b0;
        end
    end

    assign out_idx      = wcnt_q;
    assign out_blk_last = (wcnt_q == IDX_W'(15));

endmodule

// File: doc/md5_pad.md
MD5_PAD -- requirements
Module: md5_pad

Interface
- Parameters: none.
- REQ-001 The block SHALL have one clock and an asynchronous, active-high reset:
  - clk  input  1  clock; all state updates on the rising edge.
  - reset  input  1  asynchronous, active-high reset.
- REQ-002 The block SHALL have these ports, in this order after clk/reset:
  - in_valid  input  1  input word valid.
  - in_ready  output  1  block accepts the input word this cycle.
  - in_data  input  32  message word; byte 0 in bits [7:0], little-endian as MD5 requires.
  - in_last  input  1  this word is the final word of the message.
  - in_nbytes  input  3  valid bytes in the final word, 0..4; ignored when in_last=0.
  - out_valid  output  1  output word valid.
  - out_ready  input  1  downstream MD5 core accepts the output word.
  - out_data  output  32  padded block word.
  - out_idx  output  4  word index within the current 512-bit block (0..15).
  - out_blk_last  output  1  out_idx==15.
  - out_msg_last  output  1  final word of the final block (length high word).

Function
- REQ-003 An input transfer SHALL occur on in_valid&&in_ready; an output transfer SHALL occur on out_valid&&out_ready.
- REQ-004 State machine states: DATA, PAD, LEN_LO, LEN_HI.
- REQ-005 DATA state:
  - in_ready = out_ready, out_valid = in_valid, zero-latency combinational pass-through.
  - Non-last word: out_data = in_data.
- REQ-006 Last word in DATA:
  - Bytes at positions >= in_nbytes SHALL be zeroed.
  - If in_nbytes<4, byte position in_nbytes SHALL be 0x80 (marker placed).
  - If in_nbytes==4, marker_pending SHALL be set.
- REQ-007 On the last-word transfer, next state:
  - LEN_LO if the marker was placed and the next wcnt==14.
  - Otherwise PAD.
- REQ-008 PAD state:
  - in_ready=0, out_valid=1.
  - out_data = 0x00000080 if marker_pending, else 0x00000000.
  - marker_pending clears on that transfer.
  - PAD SHALL continue until the next wcnt==14 with the marker emitted, then go to LEN_LO.
- REQ-009 LEN_LO: out_valid=1, out_data = bitlen[31:0]. LEN_HI: out_valid=1, out_data = bitlen[63:32], out_msg_last=1.
- REQ-010 The LEN_HI transfer SHALL return to DATA and clear wcnt, byte count and marker_pending.
- REQ-011 wcnt (4 bits) SHALL increment on every output transfer, wrap 15->0, and drive out_idx.
- REQ-012 Byte count (61 bits) SHALL increase by 4 per non-last input word and by in_nbytes on the last word.
  - bitlen = bytecount<<3, modulo 2^64.
- REQ-013 With out_valid=1 and out_ready=0, the PAD/LEN outputs SHALL hold stable. In DATA, stability is the upstream's obligation.
- REQ-014 A last word landing at wcnt 14 or 15, or a full last word at wcnt 13, SHALL force an extra block: zeros to wcnt 15, then zeros 0..13, then length.
- REQ-015 in_last with in_nbytes=0 SHALL emit 0x00000080 in that word (this is the empty-message case).
- REQ-016 in_nbytes>4 is illegal. Behaviour is unspecified, but it SHALL not deadlock.

Reset
- REQ-017 While reset=1, the block SHALL hold: state=DATA, wcnt=0, byte count=0, marker_pending=0.
  - out_valid=0 and in_ready=0 (forced, independent of in_valid).
  - out_data=0, out_msg_last=0.
- REQ-018 Reset mid-message SHALL abandon the message. The first word after release SHALL be out_idx=0 of a new message.

Verification
- REQ-019 Empty message, in_data=0, in_nbytes=0, in_last=1 -> 16 words:
  - 0x00000080, 13x 0x0, LEN_LO=0x0, LEN_HI=0x0.
  - blk_last and msg_last on word 15.
- REQ-020 "abc", in_data=0x00636261, in_nbytes=3 -> word0=0x80636261, words 1..13=0, LEN_LO=0x00000018, LEN_HI=0.
- REQ-021 55 bytes (13 full words + last word in_nbytes=3) -> single block:
  - word13 byte3=0x80.
  - LEN_LO=0x000001B8 at idx14.
- REQ-022 56 bytes (14 full words, last in_nbytes=4) -> 32 words:
  - word14=0x00000080, words 15..29=0.
  - word30=0x000001C0, word31=0 with msg_last.
- REQ-023 out_ready held low 5 cycles during PAD and during LEN_LO -> out_data/out_idx stable, no word lost or duplicated.
- REQ-024 reset asserted in PAD -> out_valid=0 the same cycle. After release, a new "abc" message produces REQ-020 output from idx 0.
